// File: rtl/pc_mon_pkg.sv
// Shared types for the PC checkpoint monitor: FSM states, table entry layout
// and width helpers used to size ports from N_CHECK.
package pc_mon_pkg;

  localparam int CP_W_MAX = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PC,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE,
    ST_TIMEOUT
  } mon_state_t;

  // Entries are stored at the maximum width; narrower instances use the low bits.
  typedef struct packed {
    logic [CP_W_MAX-1:0] pc;
    logic [CP_W_MAX-1:0] expected;
  } checkpoint_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pc_mon_table.sv
// Checkpoint table: one register per entry, synchronous write, asynchronous
// read so the FSM sees the awaited entry in the same cycle cur_idx changes.
module pc_mon_table
  import pc_mon_pkg::*;
#(
  parameter int PC_W    = 64,
  parameter int DATA_W  = 64,
  parameter int N_CHECK = 8,
  localparam int IDX_W  = idx_w(N_CHECK)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [PC_W-1:0]   wr_pc,
  input  logic [DATA_W-1:0] wr_expected,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [PC_W-1:0]   rd_pc,
  output logic [DATA_W-1:0] rd_expected
);

  checkpoint_t entry_vec [N_CHECK];

  for (genvar gi = 0; gi < N_CHECK; gi++) begin : g_entry
    checkpoint_t entry_reg;

    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        entry_reg <= '0;
      end else if (we && (wr_idx == IDX_W'(gi))) begin
        entry_reg <= '{pc: CP_W_MAX'(wr_pc), expected: CP_W_MAX'(wr_expected)};
      end
    end

    assign entry_vec[gi] = entry_reg;
  end

  assign rd_pc       = entry_vec[rd_idx].pc[PC_W-1:0];
  assign rd_expected = entry_vec[rd_idx].expected[DATA_W-1:0];

endmodule

// File: rtl/pc_checkpoint_monitor.sv
// Self-check monitor: walks a table of (PC threshold, expected dmemout) pairs,
// scores each sample, records the first mismatch and aborts on a watchdog.
module pc_checkpoint_monitor
  import pc_mon_pkg::*;
#(
  parameter int PC_W                = 64,
  parameter int DATA_W              = 64,
  parameter int N_CHECK             = 8,
  parameter int SETTLE_CYCLES       = 1,
  parameter int WDOG_W              = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'h00FF,
  localparam int CNT_W              = cnt_w(N_CHECK),
  localparam int IDX_W              = idx_w(N_CHECK)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_checks,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [PC_W-1:0]   cfg_pc,
  input  logic [DATA_W-1:0] cfg_expected,
  input  logic [PC_W-1:0]   currentpc,
  input  logic [DATA_W-1:0] dmemout,
  output logic              busy,
  output logic              done,
  output logic              all_passed,
  output logic              timeout,
  output logic [CNT_W-1:0]  pass_count,
  output logic [IDX_W-1:0]  cur_idx,
  output logic              fail_seen,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [DATA_W-1:0] fail_actual
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  mon_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  active_reg, active_next;
  logic [CNT_W-1:0]  pass_reg, pass_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [IDX_W-1:0]  fidx_reg, fidx_next;
  logic              fail_reg, fail_next;
  logic              done_reg, done_next;
  logic              to_reg, to_next;
  logic [DATA_W-1:0] fact_reg, fact_next;
  logic [DATA_W-1:0] sample_reg, sample_next;
  logic [WDOG_W-1:0] wdog_reg, wdog_next;
  logic [SET_W-1:0]  settle_reg, settle_next;

  logic [PC_W-1:0]   tbl_pc;
  logic [DATA_W-1:0] tbl_expected;
  logic [CNT_W-1:0]  num_clamped;
  logic [WDOG_W-1:0] wdog_inc;
  logic              wdog_hit;
  logic              last_entry;

  assign busy = state_reg inside {ST_WAIT_PC, ST_SETTLE, ST_COMPARE};

  pc_mon_table #(
    .PC_W    (PC_W),
    .DATA_W  (DATA_W),
    .N_CHECK (N_CHECK)
  ) u_table (
    .CLK         (CLK),
    .reset       (reset),
    .we          (cfg_we && !busy),
    .wr_idx      (cfg_idx),
    .wr_pc       (cfg_pc),
    .wr_expected (cfg_expected),
    .rd_idx      (idx_reg),
    .rd_pc       (tbl_pc),
    .rd_expected (tbl_expected)
  );

  assign num_clamped = (num_checks > CNT_W'(N_CHECK)) ? CNT_W'(N_CHECK) : num_checks;
  assign wdog_inc    = wdog_reg + WDOG_W'(1);
  assign wdog_hit    = (wdog_inc == WDOG_LIMIT);
  assign last_entry  = ((CNT_W'(idx_reg) + CNT_W'(1)) == active_reg);

  always_comb begin
    state_next  = state_reg;
    active_next = active_reg;
    pass_next   = pass_reg;
    idx_next    = idx_reg;
    fidx_next   = fidx_reg;
    fail_next   = fail_reg;
    done_next   = done_reg;
    to_next     = to_reg;
    fact_next   = fact_reg;
    sample_next = sample_reg;
    wdog_next   = wdog_reg;
    settle_next = settle_reg;

    if (!busy) begin
      if (start) begin
        pass_next   = '0;
        fail_next   = 1'b0;
        fidx_next   = '0;
        fact_next   = '0;
        done_next   = 1'b0;
        to_next     = 1'b0;
        wdog_next   = '0;
        idx_next    = '0;
        active_next = num_clamped;
        if (num_clamped == '0) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else begin
          state_next = ST_WAIT_PC;
        end
      end
    end else if (wdog_hit) begin
      // Expiry wins over any same-cycle compare; scoreboard stays frozen.
      state_next = ST_TIMEOUT;
      to_next    = 1'b1;
      wdog_next  = wdog_inc;
    end else begin
      wdog_next = wdog_inc;
      unique case (state_reg)
        ST_WAIT_PC: begin
          if (currentpc >= tbl_pc) begin
            state_next  = ST_SETTLE;
            settle_next = SET_W'(SETTLE_CYCLES);
          end
        end
        ST_SETTLE: begin
          settle_next = settle_reg - SET_W'(1);
          if (settle_next == '0) begin
            sample_next = dmemout;
            state_next  = ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (sample_reg == tbl_expected) begin
            pass_next = pass_reg + CNT_W'(1);
          end else if (!fail_reg) begin
            fail_next = 1'b1;
            fidx_next = idx_reg;
            fact_next = sample_reg;
          end
          if (last_entry) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            idx_next   = idx_reg + IDX_W'(1);
            state_next = ST_WAIT_PC;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      active_reg <= '0;
      pass_reg   <= '0;
      idx_reg    <= '0;
      fidx_reg   <= '0;
      fail_reg   <= 1'b0;
      done_reg   <= 1'b0;
      to_reg     <= 1'b0;
      fact_reg   <= '0;
      sample_reg <= '0;
      wdog_reg   <= '0;
      settle_reg <= '0;
    end else begin
      state_reg  <= state_next;
      active_reg <= active_next;
      pass_reg   <= pass_next;
      idx_reg    <= idx_next;
      fidx_reg   <= fidx_next;
      fail_reg   <= fail_next;
      done_reg   <= done_next;
      to_reg     <= to_next;
      fact_reg   <= fact_next;
      sample_reg <= sample_next;
      wdog_reg   <= wdog_next;
      settle_reg <= settle_next;
    end
  end

  assign done        = done_reg;
  assign all_passed  = done_reg && (pass_reg == active_reg);
  assign timeout     = to_reg;
  assign pass_count  = pass_reg;
  assign cur_idx     = idx_reg;
  assign fail_seen   = fail_reg;
  assign fail_idx    = fidx_reg;
  assign fail_actual = fact_reg;

endmodule

// File: tb/tb_pc_checkpoint_monitor.sv
// Bench for pc_checkpoint_monitor: two instances (settle 1 and 3) share the
// stimulus; a cycle-count model is compared every cycle, plus literal pins.
module tb_pc_checkpoint_monitor;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  num_checks = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [63:0] cfg_pc = '0;
  logic [63:0] cfg_expected = '0;
  logic [63:0] currentpc = '0;
  logic [63:0] dmemout = '0;

  logic        busy_a, done_a, all_passed_a, timeout_a, fail_seen_a;
  logic [3:0]  pass_count_a;
  logic [2:0]  cur_idx_a, fail_idx_a;
  logic [63:0] fail_actual_a;
  logic        busy_b, done_b, all_passed_b, timeout_b, fail_seen_b;
  logic [3:0]  pass_count_b;
  logic [2:0]  cur_idx_b, fail_idx_b;
  logic [63:0] fail_actual_b;

  int n_checks = 0;
  int n_err = 0;
  int dm_mode = 0;

  localparam logic [63:0] BIG = 64'h1234_5678_9abc_def0;

  always #5 CLK = ~CLK;

  pc_checkpoint_monitor #(.SETTLE_CYCLES(1)) dut_a (
    .CLK(CLK), .reset(reset), .start(start), .num_checks(num_checks),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc), .cfg_expected(cfg_expected),
    .currentpc(currentpc), .dmemout(dmemout),
    .busy(busy_a), .done(done_a), .all_passed(all_passed_a), .timeout(timeout_a),
    .pass_count(pass_count_a), .cur_idx(cur_idx_a), .fail_seen(fail_seen_a),
    .fail_idx(fail_idx_a), .fail_actual(fail_actual_a)
  );

  pc_checkpoint_monitor #(.SETTLE_CYCLES(3)) dut_b (
    .CLK(CLK), .reset(reset), .start(start), .num_checks(num_checks),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc), .cfg_expected(cfg_expected),
    .currentpc(currentpc), .dmemout(dmemout),
    .busy(busy_b), .done(done_b), .all_passed(all_passed_b), .timeout(timeout_b),
    .pass_count(pass_count_b), .cur_idx(cur_idx_b), .fail_seen(fail_seen_b),
    .fail_idx(fail_idx_b), .fail_actual(fail_actual_b)
  );

  // Model: per instance, counts cycles since start and since the threshold hit.
  logic        m_run [2], m_done [2], m_to [2], m_fail [2];
  logic [3:0]  m_pass [2], m_active [2];
  logic [2:0]  m_idx [2], m_fidx [2];
  logic [63:0] m_fact [2], m_samp [2];
  int          m_age [2], m_hit [2];
  logic [63:0] mt_pc [2][8], mt_exp [2][8];

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [3:0] clamp(input logic [3:0] n);
    return (n > 4'd8) ? 4'd8 : n;
  endfunction

  always @(posedge CLK or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_run[k] <= 1'b0; m_done[k] <= 1'b0; m_to[k] <= 1'b0; m_fail[k] <= 1'b0;
        m_pass[k] <= '0; m_active[k] <= '0; m_idx[k] <= '0; m_fidx[k] <= '0;
        m_fact[k] <= '0; m_samp[k] <= '0; m_age[k] <= 0; m_hit[k] <= -1;
        for (int e = 0; e < 8; e++) begin
          mt_pc[k][e]  <= '0;
          mt_exp[k][e] <= '0;
        end
      end else if (m_run[k]) begin
        if (m_age[k] + 1 == 255) begin
          m_run[k] <= 1'b0;
          m_to[k]  <= 1'b1;
        end else begin
          m_age[k] <= m_age[k] + 1;
          if (m_hit[k] < 0) begin
            if (currentpc >= mt_pc[k][m_idx[k]]) m_hit[k] <= 0;
          end else if (m_hit[k] + 1 < settle_of(k)) begin
            m_hit[k] <= m_hit[k] + 1;
          end else if (m_hit[k] + 1 == settle_of(k)) begin
            m_hit[k]  <= m_hit[k] + 1;
            m_samp[k] <= dmemout;
          end else begin
            m_hit[k] <= -1;
            if (m_samp[k] == mt_exp[k][m_idx[k]]) begin
              m_pass[k] <= m_pass[k] + 4'd1;
            end else if (!m_fail[k]) begin
              m_fail[k] <= 1'b1;
              m_fidx[k] <= m_idx[k];
              m_fact[k] <= m_samp[k];
            end
            if ({1'b0, m_idx[k]} + 4'd1 == m_active[k]) begin
              m_run[k]  <= 1'b0;
              m_done[k] <= 1'b1;
            end else begin
              m_idx[k] <= m_idx[k] + 3'd1;
            end
          end
        end
      end else begin
        if (cfg_we) begin
          mt_pc[k][cfg_idx]  <= cfg_pc;
          mt_exp[k][cfg_idx] <= cfg_expected;
        end
        if (start) begin
          m_pass[k] <= '0; m_fail[k] <= 1'b0; m_fidx[k] <= '0; m_fact[k] <= '0;
          m_to[k] <= 1'b0; m_age[k] <= 0; m_hit[k] <= -1; m_idx[k] <= '0;
          m_active[k] <= clamp(num_checks);
          m_done[k] <= (clamp(num_checks) == 4'd0);
          m_run[k]  <= (clamp(num_checks) != 4'd0);
        end
      end
    end
  end

  function automatic logic [78:0] exp_vec(input int k);
    return {m_run[k], m_done[k], m_done[k] && (m_pass[k] == m_active[k]), m_to[k],
            m_pass[k], m_idx[k], m_fail[k], m_fidx[k], m_fact[k]};
  endfunction

  wire [78:0] act_a = {busy_a, done_a, all_passed_a, timeout_a, pass_count_a,
                       cur_idx_a, fail_seen_a, fail_idx_a, fail_actual_a};
  wire [78:0] act_b = {busy_b, done_b, all_passed_b, timeout_b, pass_count_b,
                       cur_idx_b, fail_seen_b, fail_idx_b, fail_actual_b};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("model_a", act_a, exp_vec(0));
    chk("model_b", act_b, exp_vec(1));
  end

  function automatic logic [63:0] dmap(input logic [63:0] pc);
    logic [63:0] p1, p2;
    p1 = (dm_mode == 2) ? 64'h40 : 64'h38;
    p2 = (dm_mode == 2) ? 64'h70 : 64'h68;
    if (pc == p1) return (dm_mode == 1) ? 64'hE : 64'hF;
    if (pc == p2) return BIG;
    return 64'h0;
  endfunction

  task automatic wr(input logic [2:0] idx, input logic [63:0] pc, input logic [63:0] ex);
    cfg_we = 1'b1; cfg_idx = idx; cfg_pc = pc; cfg_expected = ex;
    @(negedge CLK);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] n);
    num_checks = n; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic ramp(input int n);
    for (int i = 0; i < n; i++) begin
      currentpc = currentpc + 64'd4;
      dmemout   = dmap(currentpc);
      @(negedge CLK);
    end
  endtask

  task automatic load_table();
    wr(3'd0, 64'h34, 64'hF);
    wr(3'd1, 64'h64, BIG);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    repeat (2) @(negedge CLK);
    chk("reset_state_a", act_a, 79'd0);
    reset = 1'b0;
    @(negedge CLK);

    // Correct run, two checkpoints.
    load_table();
    dm_mode = 0; currentpc = 0; dmemout = 0;
    pulse_start(4'd2);
    ramp(60);
    chk("t1_done", done_a, 1'b1);
    chk("t1_all_passed", all_passed_a, 1'b1);
    chk("t1_pass_count", pass_count_a, 4'd2);
    chk("t1_fail_seen", fail_seen_a, 1'b0);
    $display("txn t1: pass_count_a=%0d pass_count_b=%0d", pass_count_a, pass_count_b);

    // First sample wrong.
    dm_mode = 1; currentpc = 0; dmemout = 0;
    pulse_start(4'd2);
    ramp(60);
    chk("t2_pass_count", pass_count_a, 4'd1);
    chk("t2_fail_seen", fail_seen_a, 1'b1);
    chk("t2_fail_idx", fail_idx_a, 3'd0);
    chk("t2_fail_actual", fail_actual_a, 64'hE);
    chk("t2_all_passed", all_passed_a, 1'b0);
    $display("txn t2: fail_idx_a=%0d fail_actual_a=%0h", fail_idx_a, fail_actual_a);

    // Stuck PC: watchdog.
    currentpc = 64'h10; dmemout = 0;
    pulse_start(4'd2);
    cnt = 0;
    while (!timeout_a && cnt < 400) begin
      @(negedge CLK);
      cnt++;
    end
    chk("t3_timeout_cycles", cnt, 255);
    chk("t3_done", done_a, 1'b0);
    chk("t3_busy", busy_a, 1'b0);
    chk("t3_timeout_b", timeout_b, 1'b1);
    $display("txn t3: timeout after %0d cycles", cnt);

    // Reset while settling, then a fresh run.
    dm_mode = 0; currentpc = 0; dmemout = 0;
    pulse_start(4'd2);
    ramp(13);
    chk("t4_busy_before_reset", busy_a, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t4_reset_a", act_a, 79'd0);
    chk("t4_reset_b", act_b, 79'd0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    load_table();
    currentpc = 0; dmemout = 0;
    pulse_start(4'd2);
    chk("t4_restart_idx", cur_idx_a, 3'd0);
    ramp(60);
    chk("t4_rerun_pass", pass_count_a, 4'd2);
    chk("t4_rerun_all_passed", all_passed_a, 1'b1);
    $display("txn t4: rerun pass_count_a=%0d", pass_count_a);

    // Empty run.
    pulse_start(4'd0);
    chk("t5_done", done_a, 1'b1);
    chk("t5_all_passed", all_passed_a, 1'b1);
    chk("t5_busy", busy_a, 1'b0);
    $display("txn t5: done_a=%0b all_passed_a=%0b", done_a, all_passed_a);

    // Samples timed for settle=3, with start and a write pulsed mid-run.
    dm_mode = 2; currentpc = 0; dmemout = 0;
    pulse_start(4'd2);
    ramp(20);
    start = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd0; cfg_pc = 64'h1000; cfg_expected = 64'h55;
    ramp(1);
    start = 1'b0; cfg_we = 1'b0;
    ramp(40);
    chk("t6_b_pass", pass_count_b, 4'd2);
    chk("t6_b_all_passed", all_passed_b, 1'b1);
    chk("t6_a_pass", pass_count_a, 4'd0);
    chk("t6_a_fail_idx", fail_idx_a, 3'd0);
    chk("t6_a_fail_actual", fail_actual_a, 64'h0);
    currentpc = 0; dmemout = 0;
    pulse_start(4'd2);
    ramp(60);
    chk("t6_b_table_intact", pass_count_b, 4'd2);
    $display("txn t6: pass_count_b=%0d pass_count_a=%0d", pass_count_b, pass_count_a);

    // Oversized num_checks clamps to the full table.
    dm_mode = 0; currentpc = 0; dmemout = 0;
    pulse_start(4'd15);
    ramp(80);
    chk("t7_clamp_pass", pass_count_a, 4'd8);
    chk("t7_clamp_idx", cur_idx_a, 3'd7);
    chk("t7_clamp_all_passed", all_passed_a, 1'b1);
    $display("txn t7: pass_count_a=%0d cur_idx_a=%0d", pass_count_a, cur_idx_a);

    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_checkpoint_monitor.md
Name: pc_checkpoint_monitor

Overview:
Synthesizable self-check monitor for the pipeline processor. It is a parametrised successor to the fixed two-checkpoint program check.
- Watches the core's currentpc and dmemout.
- Steps through a programmable table of up to N_CHECK checkpoints, each a (PC threshold, expected value) pair.
- Counts passes, reports the first failure and enforces a cycle watchdog.
- Sits beside the core at top level, usable in simulation and on FPGA.

Parameters:
PC_W, 64, width of currentpc and checkpoint PC thresholds
DATA_W, 64, width of dmemout and expected values
N_CHECK, 8, checkpoint table depth (≥1)
SETTLE_CYCLES, 1, cycles waited after the PC threshold is reached before sampling dmemout (≥1)
WDOG_W, 16, watchdog counter width
WDOG_LIMIT, 16'h00FF, cycle count since start at which the run is aborted

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a run from IDLE, DONE or TIMEOUT
num_checks  in  $clog2(N_CHECK+1)  number of active table entries, sampled at start
cfg_we  in  1  table write enable; ignored unless in IDLE/DONE/TIMEOUT
cfg_idx  in  $clog2(N_CHECK)  table write index
cfg_pc  in  PC_W  PC threshold for entry
cfg_expected  in  DATA_W  expected dmemout for entry
currentpc  in  PC_W  core program counter
dmemout  in  DATA_W  core data-memory output
busy  out  1  run in progress
done  out  1  all active checkpoints evaluated (sticky until start/reset)
all_passed  out  1  done && pass_count == active count
timeout  out  1  watchdog expired (sticky until start/reset)
pass_count  out  $clog2(N_CHECK+1)  checkpoints passed in this run
cur_idx  out  $clog2(N_CHECK)  checkpoint currently awaited
fail_seen  out  1  at least one mismatch this run
fail_idx  out  $clog2(N_CHECK)  index of first mismatch
fail_actual  out  DATA_W  dmemout captured at first mismatch

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - Table contents are cleared to 0.
  - Reset mid-run aborts immediately.
- States: IDLE, WAIT_PC, SETTLE, COMPARE, DONE, TIMEOUT.
- start in IDLE/DONE/TIMEOUT:
  - Clears pass_count, fail_*, done, timeout and the watchdog.
  - Latches num_checks and sets cur_idx=0.
  - Next state is WAIT_PC, or DONE if num_checks==0; in that case all_passed=1.
  - start during busy is ignored.
- WAIT_PC: when currentpc ≥ table[cur_idx].pc (unsigned), go to SETTLE and load the settle counter with SETTLE_CYCLES.
- SETTLE:
  - Decrement each cycle; at 0 go to COMPARE.
  - With SETTLE_CYCLES=1, dmemout is sampled exactly one cycle after the threshold cycle.
- COMPARE (one cycle):
  - If dmemout == table[cur_idx].expected, pass_count++.
  - Otherwise, if fail_seen==0, capture fail_idx=cur_idx and fail_actual=dmemout, then set fail_seen.
  - If cur_idx == active−1, go to DONE. Otherwise cur_idx++ and return to WAIT_PC.
  - Thresholds that are already satisfied pass through WAIT_PC in one cycle; there is no skipping.
- Watchdog:
  - Increments every cycle while busy.
  - When it equals WDOG_LIMIT in WAIT_PC, SETTLE or COMPARE, go to TIMEOUT and set timeout=1.
  - done stays 0; pass_count and fail_* are frozen.
  - Watchdog expiry takes priority over a same-cycle COMPARE.
- busy=1 in WAIT_PC/SETTLE/COMPARE.
- cfg writes during busy have no effect.
- A write and start in the same cycle: the write lands first, so start sees the new entry.
- num_checks > N_CHECK is clamped to N_CHECK.
- pass_count cannot overflow: its maximum is N_CHECK.

Decomposition:
- Shared package pc_mon_pkg holds:
  - the state enum;
  - the checkpoint struct {pc, expected};
  - the width helper constants.
- One natural sub-module is pc_mon_table: a register-file table with a synchronous write and an asynchronous read at cur_idx.
- The FSM, watchdog and scoreboard live in the top module.

Test Plan:
- Table {0x34→0xF, 0x64→0x123456789abcdef0}, num_checks=2, currentpc ramps by 4 per cycle, dmemout correct one cycle after each threshold:
  - done=1, all_passed=1, pass_count=2, fail_seen=0.
- Same table, dmemout=0xE at the first sample:
  - pass_count=1, fail_seen=1, fail_idx=0, fail_actual=0xE, all_passed=0.
- currentpc stuck at 0x10, WDOG_LIMIT=0xFF:
  - timeout=1 exactly 255 cycles after start, done=0, busy=0.
- Assert reset in SETTLE:
  - all outputs 0 on the next evaluation.
  - A fresh start re-runs the table from cur_idx=0, with entries reloaded.
- num_checks=0:
  - done=1 and all_passed=1 one cycle after start.
- With SETTLE_CYCLES=3, and again with start plus cfg_we pulsed while busy:
  - sampling occurs 3 cycles after the threshold.
  - The table and run are unaffected by the writes.
